// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory loader.
package riscv_pkg;

  localparam int XLEN           = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    LOAD,
    WRITE,
    DONE_WAIT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles stream bytes little-endian into one 32-bit word.
module byte_packer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic [7:0]      data,
  input  logic            last,
  output logic [XLEN-1:0] word,
  output logic [1:0]      idx
);

  // A last byte forces every lane above it to zero so a short final word is padded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (idx == 2'(k)) begin
          word[8*k +: 8] <= data;
        end else if (last && (2'(k) > idx)) begin
          word[8*k +: 8] <= '0;
        end
      end
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a byte image into instruction memory and holds the core in reset until done.
// Optional IMEM_LOADER_CSUM_EN adds a running checksum output of all written words.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_ovf
`ifdef IMEM_LOADER_CSUM_EN
  ,
  output logic [XLEN-1:0]   csum
`endif
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
  localparam logic [ADDR_W:0]   CAPACITY  = (ADDR_W + 1)'(1) << ADDR_W;

  loader_state_t     state;
  loader_state_t     next_state;
  logic              accept;
  logic              full;
  logic              last_seen;
  logic              pack_load;
  logic              pack_clear;
  logic [1:0]        pack_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W:0]   count_inc;

  assign accept    = s_valid && s_ready;
  assign full      = (word_count == CAPACITY);
  assign count_inc = word_count + (ADDR_W + 1)'(1);
  assign core_rst  = (state != DONE);
  assign load_done = (state == DONE);

  byte_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .clear (pack_clear),
    .load  (pack_load),
    .data  (s_data),
    .last  (s_last),
    .word  (imem_wdata),
    .idx   (pack_idx)
  );

  // Once memory is full, bytes are still consumed but never packed, so the stream cannot stall.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    imem_we    = 1'b0;
    pack_load  = 1'b0;
    pack_clear = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (accept) begin
          if (full) begin
            if (s_last) next_state = DONE_WAIT;
          end else begin
            pack_load = 1'b1;
            if (s_last || (pack_idx == 2'(BYTES_PER_WORD - 1))) next_state = WRITE;
          end
        end
      end
      WRITE: begin
        imem_we    = 1'b1;
        pack_clear = 1'b1;
        next_state = last_seen ? DONE_WAIT : LOAD;
      end
      DONE_WAIT: begin
        if (hold_cnt == HOLD_LAST) next_state = DONE;
      end
      DONE: begin
        if (reload) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  // The address saturates at the top word; word_count alone records the final capacity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      last_seen  <= 1'b0;
      imem_waddr <= '0;
      word_count <= '0;
      err_ovf    <= 1'b0;
      hold_cnt   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      state <= next_state;
      if (pack_load) last_seen <= s_last;
      if (state == LOAD && accept && full) err_ovf <= 1'b1;
      hold_cnt <= (state == DONE_WAIT) ? hold_cnt + HOLD_W'(1) : '0;
      if (state == WRITE) begin
        word_count <= count_inc;
        if (count_inc != CAPACITY) imem_waddr <= imem_waddr + ADDR_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
        csum <= csum + imem_wdata;
`endif
      end
      if (state == DONE && reload) begin
        imem_waddr <= '0;
        word_count <= '0;
        err_ovf    <= 1'b0;
        last_seen  <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
        csum       <= '0;
`endif
      end
    end
  end

endmodule
